regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port architectural register file for the next-generation RV32 datapath. It has NUM_RD asynchronous read ports and NUM_WR synchronous write ports. An integrated busy scoreboard tracks registers with a pending long-latency producer, such as the iterative divider. Register 0 is hard-wired to zero and is never busy.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2, >=2)
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports
AW, $clog2(NUM_REGS), address width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rd_addr  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NUM_RD*DATA_W  read data, combinational
rd_busy  out  NUM_RD  busy flag of each read address, combinational
wr_en  in  NUM_WR  write enables
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*DATA_W  write data
claim_en  in  1  mark claim_addr busy (producer issued)
claim_addr  in  AW  register being claimed
busy_vec  out  NUM_REGS  registered busy bit per register; bit 0 is always 0
busy_cnt  out  AW+1  registered population count of busy_vec

Behaviour:
- Reset (rst high at posedge clk):
  - all registers, busy_vec and busy_cnt become 0.
  - Writes and claims in a reset cycle are ignored.
  - Reset mid-operation discards all pending busy state.
- Reads:
  - rd_data[k] = regs[rd_addr[k]]; address 0 always returns 0.
  - rd_busy[k] = busy_vec[rd_addr[k]].
  - Purely combinational, zero latency.
- Writes:
  - On posedge clk, for each port j with wr_en[j]=1 and wr_addr[j]!=0, regs[wr_addr[j]] <= wr_data[j].
  - Writes to address 0 are dropped.
  - If several ports write the same address in one cycle, the highest-indexed port wins.
  - Written data is visible on rd_data from the next cycle (unless the Optional Feature is enabled).
- Scoreboard: busy bit b[r] next-state, r!=0:
  - claim_en && claim_addr==r: b <= 1. Claim beats a same-cycle write/clear (new producer supersedes).
  - else any wr_en[j] && wr_addr[j]==r: b <= 0.
  - else b holds.
  - Claim to address 0 is ignored.
  - Claim of an already-busy register keeps it busy; the scoreboard has no counting.
- busy_cnt:
  - registered; equals popcount of busy_vec (not of its next value).
  - Updates one cycle after a busy_vec change.
  - Maximum value NUM_REGS-1; the counter never wraps.
- No handshake stalls: all inputs are accepted every cycle.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through bypass.
  - If any wr_en[j] && wr_addr[j]==rd_addr[k] && rd_addr[k]!=0, rd_data[k] = that wr_data (highest j wins).
  - rd_busy[k] = 0 in the same case, unless claim_en && claim_addr==rd_addr[k].
- Undefined:
  - reads see only stored state.
  - rd_busy reflects busy_vec only.

Decomposition:
- regfile_pkg holds:
  - the default DATA_W and NUM_REGS localparams;
  - typedef reg_addr_t (logic [AW-1:0]) and reg_data_t;
  - function popcount.
- Sub-module regfile_scoreboard:
  - owns busy_vec and busy_cnt, with claim and write-clear inputs;
  - regfile_mp instantiates it once.

Test Plan:
- Reset then read: assert rst 1 cycle -> rd_data=0 and rd_busy=0 for all 32 addresses; busy_cnt=0.
- Basic write/read: wr_en=1, addr 5, data 0xDEADBEEF -> next cycle rd_addr0=5 returns 0xDEADBEEF. Write 0x1234 to addr 0 -> rd_data stays 0.
- Port collision (NUM_WR=2): both ports write addr 7, port0 0xAAAA_AAAA and port1 0x5555_5555 -> regs[7]=0x5555_5555.
- Scoreboard:
  - claim 9 -> busy_vec[9]=1 next cycle, busy_cnt=1 one cycle later;
  - write 9 -> busy cleared;
  - claim 9 and write 9 in the same cycle -> stays busy.
- Bypass:
  - with REGFILE_BYPASS_EN, write addr 3 = 0x42 while reading 3 -> rd_data=0x42 in the same cycle;
  - without the macro -> old value that cycle, 0x42 the next.
- Mid-run reset:
  - claim regs 1-31 -> busy_cnt reaches 31, no wrap;
  - assert rst -> busy_vec=0, and busy_cnt=0 the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// address/data typedefs and a population-count helper.
// Optional build macro: REGFILE_BYPASS_EN (write-through read bypass).
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  // Widest vector popcount accepts; callers zero-extend into it.
  localparam int POP_MAX = 1024;

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Number of set bits in v.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register marking a pending long-latency
// producer. A claim sets the bit, a write clears it, and a claim wins over
// a same-cycle write because the new producer supersedes the old result.
// busy_cnt is the registered popcount of the current busy_vec, so it lags
// busy_vec by one cycle. Register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  input  logic [NUM_REGS-1:0] clr_vec,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [AW:0]         busy_cnt
);

  logic [NUM_REGS-1:0] busy_next;
  logic [POP_MAX-1:0]  pop_ext;

  // Next busy state: claim has priority over clear, otherwise hold.
  always_comb begin
    busy_next = busy_vec;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (claim_en && (claim_addr == AW'(r))) begin
        busy_next[r] = 1'b1;
      end else if (clr_vec[r]) begin
        busy_next[r] = 1'b0;
      end
    end
    busy_next[0] = 1'b0;
  end

  // Zero-extend busy_vec to the popcount helper's input width.
  always_comb begin
    pop_ext = '0;
    pop_ext[NUM_REGS-1:0] = busy_vec;
  end

  // Busy state and its count; reset discards all pending producers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_next;
      busy_cnt <= (AW+1)'(popcount(pop_ext));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port architectural register file with integrated busy scoreboard.
// Reads are combinational, writes land on posedge clk, register 0 reads as
// zero and ignores writes. On a same-address write collision the
// highest-indexed write port wins.
// Handshake: none -- every input is accepted every cycle, no valid/ready.
// Optional build macro: REGFILE_BYPASS_EN makes same-cycle write data (and
// the implied busy clear) visible on the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     claim_en,
  input  logic [AW-1:0]            claim_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [AW:0]              busy_cnt
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] clr_vec;
  logic [AW-1:0]       rd_a [NUM_RD];
  logic [AW-1:0]       wr_a [NUM_WR];
  logic [DATA_W-1:0]   wr_d [NUM_WR];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_split
    assign rd_a[k] = rd_addr[k*AW +: AW];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_split
    assign wr_a[j] = wr_addr[j*AW +: AW];
    assign wr_d[j] = wr_data[j*DATA_W +: DATA_W];
  end

  // Register array update; later ports overwrite earlier ones on collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_a[j] != '0)) regs[wr_a[j]] <= wr_d[j];
      end
    end
  end

  // Any enabled write retires the producer of its destination register.
  always_comb begin
    clr_vec = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) clr_vec[wr_a[j]] = 1'b1;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .clr_vec    (clr_vec),
    .busy_vec   (busy_vec),
    .busy_cnt   (busy_cnt)
  );

  // Read ports: stored value and busy bit, optionally bypassed by writes.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_a[k] != '0) rd_data[k*DATA_W +: DATA_W] = regs[rd_a[k]];
      rd_busy[k] = busy_vec[rd_a[k]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_a[j] == rd_a[k]) && (rd_a[k] != '0)) begin
          rd_data[k*DATA_W +: DATA_W] = wr_d[j];
          if (!(claim_en && (claim_addr == rd_a[k]))) rd_busy[k] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp built with two write ports. A small reference model
// tracks registers, busy bits and the busy count; expected values are
// queued when stimulus is driven and popped when the outputs are sampled.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              claim_en;
  logic [AW-1:0]     claim_addr;
  logic [NR-1:0]     busy_vec;
  logic [AW:0]       busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] got_v;

  // reference model state
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic [AW:0]   m_cnt;

  regfile_mp #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec),
    .busy_cnt   (busy_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rst        = 1'b0;
    rd_addr    = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[j]            = 1'b1;
    wr_addr[j*AW +: AW] = a;
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic stop_wr();
    wr_en    = '0;
    claim_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] rd_d(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // Advance the model with the inputs currently applied.
  task automatic model_step();
    logic [NR-1:0] nb;
    logic [AW:0]   nc;
    logic [AW-1:0] a;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_regs[r] = '0;
      m_busy = '0;
      m_cnt  = '0;
    end else begin
      nc = (AW+1)'($countones(m_busy));
      nb = m_busy;
      for (int j = 0; j < NWR; j++) begin
        a = wr_addr[j*AW +: AW];
        if (wr_en[j]) begin
          if (a != 0) m_regs[a] = wr_data[j*DW +: DW];
          nb[a] = 1'b0;
        end
      end
      if (claim_en) nb[claim_addr] = 1'b1;
      nb[0]  = 1'b0;
      m_busy = nb;
      m_cnt  = nc;
    end
  endtask

  // One clock: update model, wait for the edge, settle just after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    set_wr(0, 5'd5, 32'hFFFF_FFFF);
    claim_en   = 1'b1;
    claim_addr = 5'd4;
    tick();
    clear_inputs();
    for (int a = 0; a < NR; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(NR - 1 - a));
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      for (int k = 0; k < NRD; k++) begin
        exp_v = exp_q.pop_front();
        got_v = rd_d(k);
        n_checks++;
        if (got_v !== exp_v) begin
          n_errors++;
          $display("FAIL reset_rd_data port%0d: got %h expected %h", k, got_v, exp_v);
        end
      end
      n_checks++;
      if (rd_busy !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_rd_busy addr %0d: got %b expected 00", a, rd_busy);
      end
    end
    n_checks++;
    if (busy_vec !== '0) begin
      n_errors++;
      $display("FAIL reset_busy_vec: got %h expected 0", busy_vec);
    end
    n_checks++;
    if (busy_cnt !== '0) begin
      n_errors++;
      $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt);
    end
  endtask

  task automatic test_basic_rw();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    set_wr(0, 5'd5, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    stop_wr();
    set_rd(0, 5'd5);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_d(0) !== exp_v) begin
      n_errors++;
      $display("FAIL basic_write5: got %h expected %h", rd_d(0), exp_v);
    end
    set_wr(0, 5'd0, 32'h0000_1234);
    exp_q.push_back(32'h0);
    tick();
    stop_wr();
    set_rd(1, 5'd0);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_d(1) !== exp_v) begin
      n_errors++;
      $display("FAIL write_addr0: got %h expected %h", rd_d(1), exp_v);
    end
    for (int i = 0; i < 16; i++) begin
      a = 5'($urandom_range(0, NR - 1));
      d = $urandom;
      set_wr(i % 2, a, d);
      exp_q.push_back((a == 0) ? 32'h0 : d);
      tick();
      stop_wr();
      set_rd(i % 2, a);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd_d(i % 2) !== exp_v) begin
        n_errors++;
        $display("FAIL random_rw addr %0d: got %h expected %h", a, rd_d(i % 2), exp_v);
      end
    end
  endtask

  task automatic test_collision();
    set_wr(0, 5'd7, 32'hAAAA_AAAA);
    set_wr(1, 5'd7, 32'h5555_5555);
    exp_q.push_back(32'h5555_5555);
    tick();
    stop_wr();
    set_rd(0, 5'd7);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_d(0) !== exp_v) begin
      n_errors++;
      $display("FAIL collision_addr7: got %h expected %h", rd_d(0), exp_v);
    end
    set_wr(0, 5'd10, 32'h0000_0A0A);
    set_wr(1, 5'd11, 32'h0000_0B0B);
    exp_q.push_back(32'h0000_0A0A);
    exp_q.push_back(32'h0000_0B0B);
    tick();
    stop_wr();
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    #1;
    for (int k = 0; k < NRD; k++) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd_d(k) !== exp_v) begin
        n_errors++;
        $display("FAIL dual_write port%0d: got %h expected %h", k, rd_d(k), exp_v);
      end
    end
  endtask

  task automatic test_scoreboard();
    set_rd(0, 5'd9);
    claim_en   = 1'b1;
    claim_addr = 5'd9;
    tick();
    stop_wr();
    #1;
    n_checks++;
    if (busy_vec[9] !== 1'b1 || rd_busy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL claim9_busy: got vec %b rd %b expected 1 1", busy_vec[9], rd_busy[0]);
    end
    n_checks++;
    if (busy_cnt !== 6'd0) begin
      n_errors++;
      $display("FAIL claim9_cnt_lag: got %0d expected 0", busy_cnt);
    end
    tick();
    n_checks++;
    if (busy_cnt !== 6'd1) begin
      n_errors++;
      $display("FAIL claim9_cnt: got %0d expected 1", busy_cnt);
    end
    set_wr(0, 5'd9, 32'h0000_0909);
    tick();
    stop_wr();
    #1;
    n_checks++;
    if (busy_vec[9] !== 1'b0 || rd_busy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL write9_clear: got vec %b rd %b expected 0 0", busy_vec[9], rd_busy[0]);
    end
    tick();
    n_checks++;
    if (busy_cnt !== 6'd0) begin
      n_errors++;
      $display("FAIL write9_cnt: got %0d expected 0", busy_cnt);
    end
    claim_en   = 1'b1;
    claim_addr = 5'd9;
    set_wr(1, 5'd9, 32'h0000_0999);
    tick();
    stop_wr();
    #1;
    n_checks++;
    if (busy_vec[9] !== 1'b1) begin
      n_errors++;
      $display("FAIL claim_beats_write: got %b expected 1", busy_vec[9]);
    end
    claim_en   = 1'b1;
    claim_addr = 5'd9;
    tick();
    claim_addr = 5'd0;
    tick();
    stop_wr();
    tick();
    n_checks++;
    if (busy_vec !== 32'h0000_0200 || busy_vec !== m_busy) begin
      n_errors++;
      $display("FAIL reclaim_claim0: got %h expected %h", busy_vec, 32'h0000_0200);
    end
    n_checks++;
    if (busy_cnt !== 6'd1 || busy_cnt !== m_cnt) begin
      n_errors++;
      $display("FAIL reclaim_cnt: got %0d expected 1", busy_cnt);
    end
    set_wr(0, 5'd9, 32'h0);
    tick();
    stop_wr();
  endtask

  task automatic test_bypass();
    set_wr(0, 5'd3, 32'h0000_0011);
    claim_en   = 1'b1;
    claim_addr = 5'd3;
    tick();
    stop_wr();
    claim_en   = 1'b1;
    claim_addr = 5'd3;
    tick();
    stop_wr();
    set_rd(0, 5'd3);
    set_rd(1, 5'd0);
    set_wr(0, 5'd3, 32'h0000_0042);
    set_wr(1, 5'd0, 32'hFFFF_0000);
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h0000_0042);
`else
    exp_q.push_back(32'h0000_0011);
`endif
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd_d(0) !== exp_v) begin
      n_errors++;
      $display("FAIL bypass_same_cycle: got %h expected %h", rd_d(0), exp_v);
    end
    n_checks++;
`ifdef REGFILE_BYPASS_EN
    if (rd_busy[0] !== 1'b0) begin
`else
    if (rd_busy[0] !== 1'b1) begin
`endif
      n_errors++;
      $display("FAIL bypass_busy: got %b", rd_busy[0]);
    end
    n_checks++;
    if (rd_d(1) !== 32'h0) begin
      n_errors++;
      $display("FAIL bypass_addr0: got %h expected 0", rd_d(1));
    end
    tick();
    stop_wr();
    #1;
    n_checks++;
    if (rd_d(0) !== 32'h0000_0042 || rd_busy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL bypass_next_cycle: got %h busy %b expected 00000042 busy 0", rd_d(0), rd_busy[0]);
    end
  endtask

  task automatic test_midrun_reset();
    for (int r = 1; r < NR; r++) begin
      claim_en   = 1'b1;
      claim_addr = 5'(r);
      tick();
      n_checks++;
      if (busy_cnt !== m_cnt || busy_vec !== m_busy) begin
        n_errors++;
        $display("FAIL claim_ramp r%0d: got cnt %0d vec %h expected cnt %0d vec %h",
                 r, busy_cnt, busy_vec, m_cnt, m_busy);
      end
    end
    claim_addr = 5'd5;
    tick();
    tick();
    stop_wr();
    n_checks++;
    if (busy_cnt !== 6'd31 || busy_vec !== 32'hFFFF_FFFE) begin
      n_errors++;
      $display("FAIL full_busy: got cnt %0d vec %h expected 31 fffffffe", busy_cnt, busy_vec);
    end
    rst        = 1'b1;
    claim_en   = 1'b1;
    claim_addr = 5'd6;
    set_wr(0, 5'd5, 32'h1234_5678);
    tick();
    clear_inputs();
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    #1;
    n_checks++;
    if (busy_vec !== '0 || busy_cnt !== '0) begin
      n_errors++;
      $display("FAIL midrun_reset: got vec %h cnt %0d expected 0 0", busy_vec, busy_cnt);
    end
    n_checks++;
    if (rd_d(0) !== 32'h0 || rd_busy !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_write_ignored: got %h busy %b expected 0 00", rd_d(0), rd_busy);
    end
    tick();
    n_checks++;
    if (busy_cnt !== 6'd0) begin
      n_errors++;
      $display("FAIL post_reset_cnt: got %0d expected 0", busy_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_basic_rw();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_midrun_reset();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
